// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (OP_PASS .. OP_MUL; 12-15 reserved)
//   - FSM state encoding (S_IDLE, S_MUL, S_DONE)
//   - flag bank layout {carry, overflow, zero, negative}
package alu_pkg;

  localparam logic [3:0] OP_PASS   = 4'd0;
  localparam logic [3:0] OP_NOT    = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_NEG    = 4'd6;
  localparam logic [3:0] OP_NEGSEL = 4'd7;
  localparam logic [3:0] OP_SHL    = 4'd8;
  localparam logic [3:0] OP_SHR    = 4'd9;
  localparam logic [3:0] OP_SRA    = 4'd10;
  localparam logic [3:0] OP_MUL    = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, reset (async, active-low)
//   load     : capture a/b, clear accumulator and step counter
//   a, b     : operands (sampled on load)
//   product  : accumulator value after the current cycle's step
//   last     : the current cycle performs the final (WIDTH-th) step
// The multiplier keeps stepping after the final step; the owner only looks
// at product/last while it is waiting for a multiply to finish.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam logic [WIDTH-1:0] LAST_STEP = WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_acc_next;

  // Lookahead: exposing the post-step value lets the owner capture the full
  // product on the same edge that performs the final step.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign product    = w_acc_next;
  assign last       = (r_cnt == LAST_STEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= '0;
    end else begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + ONE;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered datapath ALU with iterative multiply and two flag banks.
// Ports:
//   clk, reset (async, active-low)
//   start, a, b, op_alu, s_inm, interruption : request and its operands
//   intr_clr   : synchronous clear of the interrupt flag bank (wins over a write)
//   y, y_hi    : registered result (y_hi is the upper product half for MUL, else 0)
//   busy, done : handshake status
//   carry/overflow/zero/negative[_intr] : normal / interrupt flag banks
//   dbg_state  : current FSM state
// Handshake: start is sampled only in IDLE. A non-MUL op goes IDLE->DONE on
// the start edge; MUL raises busy for WIDTH cycles and then goes to DONE.
// done is high for exactly the one cycle spent in DONE, and y, y_hi and the
// selected flag bank change on the edge that raises done. start during busy
// or DONE is ignored, so each op takes at least two cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_alu,
  input  logic             s_inm,
  input  logic             interruption,
  input  logic             intr_clr,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             carry_intr,
  output logic             overflow_intr,
  output logic             zero_intr,
  output logic             negative_intr,
  output logic [1:0]       dbg_state
);

  localparam int               MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_intr;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_y_hi;
  flags_t             r_fn;
  flags_t             r_fi;

  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_m;
  logic [WIDTH-1:0]   w_s;
  logic [WIDTH-1:0]   w_x;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_wide;
  logic [SHW-1:0]     w_amt;
  logic               w_c;
  logic               w_v;
  logic               w_upd;
  flags_t             w_flags;
  flags_t             w_mflags;
  logic [2*WIDTH-1:0] w_product;
  logic               w_last;
  logic               w_load;

  // Operand routing for the swappable subtract and the selectable negate.
  assign w_m   = s_inm ? b : a;
  assign w_s   = s_inm ? a : b;
  assign w_x   = ((op_alu == OP_NEG) || s_inm) ? a : b;
  assign w_amt = b[SHW-1:0];

  always_comb begin
    w_res  = '0;
    w_sum  = '0;
    w_wide = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_upd  = 1'b1;
    case (op_alu)
      OP_PASS: w_res = a;
      OP_NOT:  w_res = ~a;
      OP_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        w_res = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[MSB] == b[MSB]) && (w_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_res = w_m - w_s;
        w_c   = (w_m < w_s);
        w_v   = (w_m[MSB] != w_s[MSB]) && (w_res[MSB] != w_m[MSB]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_NEG, OP_NEGSEL: begin
        w_res = '0 - w_x;
        w_c   = |w_x;
        w_v   = (w_x == MIN_NEG);
      end
      // Shifts run on a WIDTH+1 bit vector so the bit shifted out lands in
      // the extra position; a zero amount leaves that position 0.
      OP_SHL: begin
        w_wide       = {1'b0, a} << w_amt;
        {w_c, w_res} = w_wide;
      end
      OP_SHR: begin
        w_wide       = {a, 1'b0} >> w_amt;
        {w_res, w_c} = w_wide;
      end
      OP_SRA: begin
        w_wide       = $signed({a, 1'b0}) >>> w_amt;
        {w_res, w_c} = w_wide;
      end
      default: w_upd = 1'b0;  // MUL is handled by the FSM; 12-15 leave state alone
    endcase

    w_flags.carry       = w_c;
    w_flags.overflow    = w_v;
    w_flags.zero        = (w_res == '0);
    w_flags.negative    = w_res[MSB];

    w_mflags.carry      = |w_product[2*WIDTH-1:WIDTH];
    w_mflags.overflow   = |w_product[2*WIDTH-1:WIDTH];
    w_mflags.zero       = (w_product[MSB:0] == '0);
    w_mflags.negative   = w_product[MSB];
  end

  assign w_load = (r_state == S_IDLE) && start && (op_alu == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .a       (a),
    .b       (b),
    .product (w_product),
    .last    (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_intr  <= 1'b0;
      r_y     <= '0;
      r_y_hi  <= '0;
      r_fn    <= '0;
      r_fi    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (op_alu == OP_MUL) begin
              r_intr  <= interruption;
              r_busy  <= 1'b1;
              r_state <= S_MUL;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
              if (w_upd) begin
                r_y    <= w_res;
                r_y_hi <= '0;
                if (interruption) r_fi <= w_flags;
                else              r_fn <= w_flags;
              end
            end
          end
        end
        S_MUL: begin
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
            r_y     <= w_product[MSB:0];
            r_y_hi  <= w_product[2*WIDTH-1:WIDTH];
            if (r_intr) r_fi <= w_mflags;
            else        r_fn <= w_mflags;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // Placed last so a coinciding interrupt-bank write is overridden.
      if (intr_clr) r_fi <= '0;
    end
  end

  assign y             = r_y;
  assign y_hi          = r_y_hi;
  assign busy          = r_busy;
  assign done          = r_done;
  assign carry         = r_fn.carry;
  assign overflow      = r_fn.overflow;
  assign zero          = r_fn.zero;
  assign negative      = r_fn.negative;
  assign carry_intr    = r_fi.carry;
  assign overflow_intr = r_fi.overflow;
  assign zero_intr     = r_fi.zero;
  assign negative_intr = r_fi.negative;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (WIDTH=16) with a behavioural
// model, an every-cycle compare process and a done-time expected queue.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op_alu;
  logic         s_inm;
  logic         interruption;
  logic         intr_clr;
  logic [W-1:0] y;
  logic [W-1:0] y_hi;
  logic         busy;
  logic         done;
  logic         carry, overflow, zero, negative;
  logic         carry_intr, overflow_intr, zero_intr, negative_intr;
  logic [1:0]   dbg_state;

  alu_seq #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .a             (a),
    .b             (b),
    .op_alu        (op_alu),
    .s_inm         (s_inm),
    .interruption  (interruption),
    .intr_clr      (intr_clr),
    .y             (y),
    .y_hi          (y_hi),
    .busy          (busy),
    .done          (done),
    .carry         (carry),
    .overflow      (overflow),
    .zero          (zero),
    .negative      (negative),
    .carry_intr    (carry_intr),
    .overflow_intr (overflow_intr),
    .zero_intr     (zero_intr),
    .negative_intr (negative_intr),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_y   = '0;
  logic [W-1:0] exp_hi  = '0;
  logic [3:0]   exp_fn  = '0;   // {carry, overflow, zero, negative}
  logic [3:0]   exp_fi  = '0;
  logic         exp_busy = 1'b0;
  logic         exp_done = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void model(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                input bit s, output bit upd, output logic [W-1:0] ey,
                                output logic [W-1:0] ehi, output logic [3:0] ef);
    longint ua, ub, um, us, sa, sb, sm, ss, r, sr;
    int amt;
    bit c, v;
    ua = av; ub = bv;
    sa = $signed(av); sb = $signed(bv);
    amt = int'(bv[3:0]);
    upd = 1'b1; c = 1'b0; v = 1'b0; r = 0; ehi = '0;
    case (op)
      4'd0: r = ua;
      4'd1: r = ua ^ 'hFFFF;
      4'd2: begin
        r = ua + ub; c = (r > 'hFFFF);
        sr = sa + sb; v = (sr > 32767) || (sr < -32768);
      end
      4'd3: begin
        if (s) begin um = ub; us = ua; sm = sb; ss = sa; end
        else   begin um = ua; us = ub; sm = sa; ss = sb; end
        r = um - us; c = (um < us);
        sr = sm - ss; v = (sr > 32767) || (sr < -32768);
      end
      4'd4: r = ua & ub;
      4'd5: r = ua | ub;
      4'd6, 4'd7: begin
        um = (op == 4'd6 || s) ? ua : ub;
        r = -um; c = (um != 0); v = (um == 'h8000);
      end
      4'd8: begin
        r = ua << amt;
        if (amt != 0) c = ((r >> 16) & 1) == 1;
      end
      4'd9, 4'd10: begin
        r = (op == 4'd9) ? (ua >> amt) : (sa >>> amt);
        if (amt != 0) c = ((ua >> (amt - 1)) & 1) == 1;
      end
      4'd11: begin
        r = ua * ub;
        ehi = 16'(r >> 16);
        c = (ehi != 0); v = c;
      end
      default: upd = 1'b0;
    endcase
    ey = 16'(r);
    ef = {c, v, (ey == 16'h0000), ey[15]};
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      chk("busy", {15'b0, busy}, {15'b0, exp_busy});
      chk("done", {15'b0, done}, {15'b0, exp_done});
      chk("y", y, exp_y);
      chk("y_hi", y_hi, exp_hi);
      chk("flags_norm", {12'b0, carry, overflow, zero, negative}, {12'b0, exp_fn});
      chk("flags_intr", {12'b0, carry_intr, overflow_intr, zero_intr, negative_intr}, {12'b0, exp_fi});
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("done_y", y, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // poke: for MUL, pulse a conflicting start mid-iteration; otherwise hold
  // start high through the DONE cycle. Both must be ignored.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit s, input bit intr, input bit clr, input bit poke);
    bit           upd;
    logic [W-1:0] ey, ehi;
    logic [3:0]   ef;
    model(op, av, bv, s, upd, ey, ehi, ef);
    @(negedge clk);
    op_alu = op; a = av; b = bv; s_inm = s; interruption = intr; start = 1'b1;
    if (op == 4'd11) begin
      @(posedge clk); #1;
      start = 1'b0; exp_busy = 1'b1;
      for (int i = 1; i < W; i++) begin
        if (poke && i == 5) begin
          @(negedge clk);
          start = 1'b1; op_alu = 4'd2; a = 16'hFFFF; b = 16'h0001; interruption = ~intr;
          @(posedge clk); #1;
          start = 1'b0;
        end else begin
          @(posedge clk); #1;
        end
      end
      @(negedge clk);
      intr_clr = clr;
      @(posedge clk); #1;
      intr_clr = 1'b0; exp_busy = 1'b0;
    end else begin
      intr_clr = clr;
      @(posedge clk); #1;
      intr_clr = 1'b0;
      if (!poke) start = 1'b0;
    end
    exp_done = 1'b1;
    if (upd) begin
      exp_y = ey; exp_hi = ehi;
      if (intr) exp_fi = ef;
      else      exp_fn = ef;
    end
    if (clr) exp_fi = '0;
    exp_q.push_back(exp_y);
    @(posedge clk); #1;
    start = 1'b0;
    exp_done = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0; start = 1'b0; a = '0; b = '0; op_alu = '0;
    s_inm = 1'b0; interruption = 1'b0; intr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_y", y, 16'h0000);
    chk("reset_state", {14'b0, dbg_state}, 16'h0000);
    reset = 1'b1;
    @(negedge clk);

    run_op(4'd2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_y", y, 16'h8000);
    chk("add_fn", {12'b0, carry, overflow, zero, negative}, 16'h0005);

    run_op(4'd3, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("subsw_y", y, 16'hFFFE);
    chk("subsw_fi", {12'b0, carry_intr, overflow_intr, zero_intr, negative_intr}, 16'h0009);
    chk("subsw_fn_kept", {12'b0, carry, overflow, zero, negative}, 16'h0005);

    run_op(4'd11, 16'h1234, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mul_y", y, 16'h3400);
    chk("mul_yhi", y_hi, 16'h0012);
    chk("mul_fn", {12'b0, carry, overflow, zero, negative}, 16'h000C);

    run_op(4'd10, 16'h8001, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sra_y", y, 16'hF800);
    chk("sra_fn", {12'b0, carry, overflow, zero, negative}, 16'h0001);

    run_op(4'd9, 16'h0008, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("shr_y", y, 16'h0000);
    chk("shr_fn", {12'b0, carry, overflow, zero, negative}, 16'h000A);

    run_op(4'd6, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("neg_y", y, 16'h8000);
    chk("neg_fn", {12'b0, carry, overflow, zero, negative}, 16'h000D);

    run_op(4'd0, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(4'd1, 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(4'd4, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(4'd5, 16'h0F00, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(4'd7, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(4'd7, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(4'd8, 16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(4'd8, 16'h8001, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(4'd2, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(4'd3, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(4'd3, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(4'd13, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(4'd11, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(4'd11, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_fi", {12'b0, carry_intr, overflow_intr, zero_intr, negative_intr}, 16'h0000);
    chk("clr_y", y, 16'h0001);

    // Reset asserted in cycle 5 of a multiply: outputs clear at once, no done.
    @(negedge clk);
    op_alu = 4'd11; a = 16'h00FF; b = 16'h00FF; interruption = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; exp_busy = 1'b1;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_y", y, 16'h0000);
    chk("rst_mid_busy", {15'b0, busy}, 16'h0000);
    chk("rst_mid_fn", {12'b0, carry, overflow, zero, negative}, 16'h0000);
    exp_busy = 1'b0; exp_y = '0; exp_hi = '0; exp_fn = '0; exp_fi = '0;
    @(negedge clk); #1;
    reset = 1'b1;
    repeat (20) @(negedge clk);

    run_op(4'd2, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_y", y, 16'h0003);

    repeat (2) @(negedge clk);
    chk("queue_empty", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Next-generation, parameterised datapath ALU for the CPU core. It replaces the purely combinational ALU.
- Operands, opcode and context are registered on a start/done handshake.
- An iterative shift-add multiplier and barrel shifts are added to the opcode set.
- Flags are held in two registered banks, normal and interrupt. This removes the combinational flag feedback loops.
- Sits between the register file / immediate mux and the writeback mux. The control unit stalls on busy.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op_alu  in  4  opcode (see Behaviour).
- s_inm  in  1  operand-swap select for ops 3 and 7.
- interruption  in  1  selects the flag bank written by this operation; sampled at start.
- intr_clr  in  1  synchronous clear of the interrupt flag bank.
- y  out  WIDTH  registered result.
- y_hi  out  WIDTH  upper product half for MUL; 0 for all other ops.
- busy  out  1  high while a MUL is iterating.
- done  out  1  one-cycle pulse: y, y_hi and flags updated this cycle.
- carry, overflow, zero, negative  out  1 each  normal flag bank.
- carry_intr, overflow_intr, zero_intr, negative_intr  out  1 each  interrupt flag bank.

Behaviour:
- Reset (asynchronous, reset=0): all outputs and internal registers are 0; FSM goes to IDLE. Reset asserted mid-MUL aborts it; no done is produced.
- FSM has three states: IDLE, MUL, DONE.
  - IDLE & start & op≠11: latch operands, compute, go to DONE. y and flags are visible one cycle after the start edge.
  - IDLE & start & op=11: latch a, b and the bank select, clear the accumulator, set busy=1, go to MUL.
  - MUL: one shift-add step per cycle, using a WIDTH-bit counter. After WIDTH steps, go to DONE and drop busy in the same edge. Latency from the start edge to done is WIDTH+1 cycles.
  - DONE: done=1 for exactly one cycle, then IDLE. start during DONE is ignored (no back-to-back issue; minimum 2 cycles per op).
- start while busy=1 or in DONE: ignored. Latched operands are unaffected.
- Opcodes:
  - 0 y=a
  - 1 y=~a
  - 2 y=a+b
  - 3 y = s_inm ? b−a : a−b
  - 4 y=a&b
  - 5 y=a|b
  - 6 y=−a
  - 7 y = s_inm ? −a : −b
  - 8 SHL a by b[SHW-1:0]
  - 9 SHR logical
  - 10 SRA arithmetic
  - 11 MUL unsigned a×b: {y_hi,y} = 2·WIDTH product
  - 12–15 reserved: done still pulses; y, y_hi and flags are unchanged.
- Flag rules (the bank is written only in the done cycle, and only the bank selected by the latched interruption):
  - zero = (y==0)
  - negative = y[WIDTH-1]
  - carry:
    - add: true carry out of the WIDTH+1-bit sum.
    - sub: borrow, i.e. minuend < subtrahend unsigned.
    - negate: 1 unless the operand is 0.
    - shifts: last bit shifted out; 0 if the amount is 0.
    - MUL: y_hi≠0.
    - ops 0, 1, 4, 5: 0.
  - overflow:
    - add/sub: signed two's-complement overflow.
    - negate: operand = 100…0.
    - MUL: y_hi≠0.
    - all others: 0.
- intr_clr=1 zeroes the interrupt bank at the next edge. If it coincides with a done that targets the interrupt bank, the clear wins. The normal bank is never affected by intr_clr.
- Flag banks hold their value between operations; there are no combinational paths from inputs to flags.

Decomposition:
- Package alu_pkg:
  - opcode localparams: OP_PASS=0 … OP_MUL=11.
  - FSM state encoding: IDLE, MUL, DONE.
  - flag-bank struct order {carry, overflow, zero, negative}.
- One sub-module, alu_mul_iter: a shift-add multiplier.
  - Inputs: clk, reset, load, a, b.
  - Outputs: product[2·WIDTH-1:0], last.
  - Instantiated once; the top holds the FSM, the combinational op unit and the flag banks.

Test Plan (WIDTH=16):
- Add carry/overflow: op=2, a=0x7FFF, b=0x0001, interruption=0 → y=0x8000 one cycle after start; overflow=1, negative=1, carry=0, zero=0; interrupt bank unchanged.
- Swapped sub, interrupt bank: op=3, s_inm=1, a=5, b=3, interruption=1 → y=0xFFFE, carry_intr=1, negative_intr=1; normal flags keep their previous values.
- Multiply: op=11, a=0x1234, b=0x0100 → busy for 16 cycles, done at cycle 17; y=0x3400, y_hi=0x0012, carry=overflow=1. start pulsed mid-MUL has no effect.
- Shifts: op=10, a=0x8001, b=4 → y=0xF800, carry=0. op=9, a=0x0008, b=4 → y=0x0000, zero=1, carry=1.
- Negate edge case: op=6, a=0x8000 → y=0x8000, overflow=1, carry=1.
- Reset and clear: reset=0 at cycle 5 of a MUL → all outputs 0 immediately, no done. Separately, intr_clr coincident with done targeting the interrupt bank → interrupt bank = 0.
